core_seq_ctrl: RTL and testbench
================================

// Module: core_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I core. Owns the PC and instruction register, and drives imem/dmem handshakes.
//  Steps each instruction through decode/execute/memory/writeback and issues the register-file write strobe.
//  One instruction in flight. Sits between the memory ports and the decoder/ALU/regfile datapath.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  CNT_W     32             width of retired-instruction counter
// PORTS
//  clk_i           in   1      clock
//  rst_ni          in   1      reset, asynchronous, active-low
//  imem_req_o      out  1      fetch request
//  imem_addr_o     out  32     fetch address, always equals pc_o
//  imem_gnt_i      in   1      fetch request accepted
//  imem_rvalid_i   in   1      fetch data valid
//  imem_rdata_i    in   32     fetch data
//  inst_o          out  32     instruction register, drives decoder inst_i
//  format_i        in   types::inst_format_e  decoder classification of inst_o
//  pc_o            out  32     PC of current instruction
//  branch_taken_i  in   1      ALU compare result, valid in EXEC
//  target_i        in   32     ALU jump/branch target, valid in EXEC
//  dmem_req_o      out  1      data request
//  dmem_we_o       out  1      1 = store, 0 = load; valid while dmem_req_o
//  dmem_gnt_i      in   1      data request accepted
//  dmem_rvalid_i   in   1      load data valid / store ack
//  rf_we_o         out  1      regfile write strobe, one cycle
//  wb_sel_o        out  2      writeback source: 0 ALU, 1 load data, 2 PC+4
//  trap_o          out  1      sticky trap (illegal or misaligned)
//  instret_o       out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset values: state=FETCH, pc_o=RESET_PC, inst_o=32'h0000_0013 (NOP).
//   All strobes and requests 0, wb_sel_o=0, trap_o=0, instret_o=0.
//  States: FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT, WB, TRAP.
//  Request handshake (both ports):
//   - req held high, address stable, until gnt is seen.
//   - rvalid must come at least 1 cycle after gnt; 1 outstanding max.
//   - rvalid in any state other than FWAIT/MWAIT is ignored (covers stale responses after reset).
//  FETCH: imem_req_o=1; imem_gnt_i -> FWAIT.
//  FWAIT: imem_rvalid_i -> inst_o<=imem_rdata_i, -> DECODE.
//  DECODE: 1 cycle. format_i==INVALID_TYPE -> TRAP; else -> EXEC.
//  EXEC: 1 cycle; opcode = inst_o[6:0].
//   - Latch branch_taken_i and target_i.
//   - load 0000011 or store 0100011 -> MEM; else -> WB.
//   - Redirect (JAL 1101111, JALR 1100111, or branch 1100011 with taken) with target[1:0]!=0 -> TRAP; pc_o unchanged.
//  MEM: dmem_req_o=1, dmem_we_o=(store); dmem_gnt_i -> MWAIT.
//  MWAIT: dmem_rvalid_i -> WB.
//  WB: 1 cycle, then -> FETCH.
//   - rf_we_o=1 except store/branch.
//   - wb_sel_o: 1 load; 2 JAL/JALR; 0 all others.
//   - pc_o <= latched target if JAL/JALR/taken branch; else pc_o+4 (mod 2^32).
//   - instret_o++ (wraps to 0 at 2^CNT_W).
//  TRAP: terminal; trap_o=1, no requests, rf_we_o=0; left only by reset.
//  Latency, zero-wait memory (gnt in request cycle, rvalid next cycle):
//   ALU/branch/jump = 5 cycles, load/store = 7 cycles.
//  Reset asserted mid-operation: immediate return to reset values; any pending request is abandoned.
// TESTING
//  1) Reset, ADDI at 0x0, zero-wait imem -> imem_req_o at cycle 0; rf_we_o pulse at cycle 4, wb_sel_o=0; pc_o=0x4; instret_o=1.
//  2) LW with dmem_gnt_i delayed 3 cycles -> dmem_req_o/dmem_we_o=0 held 4 cycles; rf_we_o with wb_sel_o=1 after rvalid.
//  3) BEQ taken, target 0x40 -> pc_o=0x40, rf_we_o never high. Not taken -> pc_o=old+4.
//  4) JAL at 0xFFFF_FFFC, target 0x8 -> wb_sel_o=2, pc_o=0x8. NOP at 0xFFFF_FFFC -> pc_o wraps to 0x0.
//  5) Word 0x0000_0000 (INVALID_TYPE) -> TRAP, trap_o=1 sticky, no further imem_req_o. JALR target 0x102 -> TRAP.
//  6) rst_ni low during MWAIT -> outputs at reset values; late dmem_rvalid_i ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle RV32I sequencer. Owns PC and instruction
// register, runs the imem/dmem request handshakes and steps each
// instruction through decode/exec/mem/writeback, one in flight.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   imem_req/addr/gnt/rvalid/rdata instruction fetch port
//   inst_o, format_i               instruction to decoder, its class back
//   pc_o                           PC of current instruction
//   branch_taken_i, target_i       ALU compare result and target (EXEC)
//   dmem_req/we/gnt/rvalid         data port handshake
//   rf_we_o, wb_sel_o              regfile write strobe and source select
//   trap_o, instret_o              sticky trap, retired-instruction count

package types;
  typedef enum logic [2:0] {
    R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, INVALID_TYPE
  } inst_format_e;
endpackage

module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                imem_req_o,
  output logic [31:0]         imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [31:0]         imem_rdata_i,
  output logic [31:0]         inst_o,
  input  types::inst_format_e format_i,
  output logic [31:0]         pc_o,
  input  logic                branch_taken_i,
  input  logic [31:0]         target_i,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  output logic                rf_we_o,
  output logic [1:0]          wb_sel_o,
  output logic                trap_o,
  output logic [CNT_W-1:0]    instret_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic             taken_q, taken_d;
  logic [31:0]      target_q, target_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic imem_req, dmem_req, dmem_we, rf_we, trap;
  logic [1:0] wb_sel;

  logic [6:0] opcode;
  logic is_load, is_store, is_branch, is_jump;

  assign opcode    = inst_q[6:0];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0013;
      taken_q   <= 1'b0;
      target_q  <= 32'h0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    taken_d   = taken_q;
    target_d  = target_q;
    instret_d = instret_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt_i) state_d = S_FWAIT;
      end
      S_FWAIT: begin
        if (imem_rvalid_i) begin
          inst_d  = imem_rdata_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (format_i == types::INVALID_TYPE) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        taken_d  = branch_taken_i;
        target_d = target_i;
        // misaligned redirect traps with pc untouched
        if ((is_jump || (is_branch && branch_taken_i)) && (target_i[1:0] != 2'b00))
          state_d = S_TRAP;
        else if (is_load || is_store)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_gnt_i) state_d = S_MWAIT;
      end
      S_MWAIT: begin
        if (dmem_rvalid_i) state_d = S_WB;
      end
      S_WB: begin
        rf_we     = !(is_store || is_branch);
        wb_sel    = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
        pc_d      = (is_jump || (is_branch && taken_q)) ? target_q : pc_q + 32'd4;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // FETCH is the reset state; keep the fetch request quiet while reset is held
  assign imem_req_o  = imem_req & rst_ni;
  assign imem_addr_o = pc_q;
  assign inst_o      = inst_q;
  assign pc_o        = pc_q;
  assign dmem_req_o  = dmem_req;
  assign dmem_we_o   = dmem_we;
  assign rf_we_o     = rf_we;
  assign wb_sel_o    = wb_sel;
  assign trap_o      = trap;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

  localparam logic [31:0] W_ADDI = 32'h0010_0093;
  localparam logic [31:0] W_LW   = 32'h0000_2083;
  localparam logic [31:0] W_BEQ  = 32'h0000_0063;
  localparam logic [31:0] W_JAL  = 32'h0000_006F;
  localparam logic [31:0] W_JALR = 32'h0000_8067;
  localparam logic [31:0] W_NOP  = 32'h0000_0013;
  localparam logic [31:0] W_BAD  = 32'h0000_0000;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i, inst_o, pc_o, target_i;
  types::inst_format_e format_i;
  logic branch_taken_i;
  logic dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic rf_we_o, trap_o;
  logic [1:0] wb_sel_o;
  logic [31:0] instret_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem_word;
  int i_gnt_dly = 0, i_rv_dly = 0, d_gnt_dly = 0, d_rv_dly = 0;

  always #5 clk_i = ~clk_i;

  core_seq_ctrl #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_o(inst_o), .format_i(format_i), .pc_o(pc_o),
    .branch_taken_i(branch_taken_i), .target_i(target_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
    .trap_o(trap_o), .instret_o(instret_o)
  );

  function automatic types::inst_format_e dec(input logic [31:0] w);
    case (w[6:0])
      7'b0110011:                     dec = types::R_TYPE;
      7'b0010011, 7'b0000011, 7'b1100111: dec = types::I_TYPE;
      7'b0100011:                     dec = types::S_TYPE;
      7'b1100011:                     dec = types::B_TYPE;
      7'b0110111, 7'b0010111:         dec = types::U_TYPE;
      7'b1101111:                     dec = types::J_TYPE;
      default:                        dec = types::INVALID_TYPE;
    endcase
  endfunction

  assign format_i = dec(inst_o);

  // instruction memory responder: gnt after i_gnt_dly waiting cycles, rvalid i_rv_dly+1 after gnt
  initial begin
    bit pend;
    int cnt, wt;
    pend = 0; cnt = 0; wt = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    forever begin
      @(negedge clk_i);
      imem_gnt_i = 0; imem_rvalid_i = 0;
      if (pend) begin
        if (cnt == 0) begin imem_rvalid_i = 1; imem_rdata_i = imem_word; pend = 0; end
        else cnt--;
      end else if (rst_ni && imem_req_o) begin
        if (wt == 0) begin imem_gnt_i = 1; pend = 1; cnt = i_rv_dly; end
        else wt--;
      end
      if (!rst_ni || !imem_req_o || imem_gnt_i) wt = i_gnt_dly;
    end
  end

  // data memory responder, same scheme; a pending response survives reset
  initial begin
    bit pend;
    int cnt, wt;
    pend = 0; cnt = 0; wt = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0;
    forever begin
      @(negedge clk_i);
      dmem_gnt_i = 0; dmem_rvalid_i = 0;
      if (pend) begin
        if (cnt == 0) begin dmem_rvalid_i = 1; pend = 0; end
        else cnt--;
      end else if (rst_ni && dmem_req_o) begin
        if (wt == 0) begin dmem_gnt_i = 1; pend = 1; cnt = d_rv_dly; end
        else wt--;
      end
      if (!rst_ni || !dmem_req_o || dmem_gnt_i) wt = d_gnt_dly;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // leaves time at cycle 0 of the first instruction after reset
  task automatic do_reset();
    rst_ni = 1'b0;
    i_gnt_dly = 0; i_rv_dly = 0; d_gnt_dly = 0; d_rv_dly = 0;
    branch_taken_i = 1'b0; target_i = 32'h0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    imem_word = W_ADDI;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (pc_o !== 32'h0 || inst_o !== W_NOP || instret_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: pc=%h inst=%h instret=%0d, want pc=0 inst=00000013 instret=0", pc_o, inst_o, instret_o);
    end
    checks++;
    if ({imem_req_o, dmem_req_o, dmem_we_o, rf_we_o, trap_o, wb_sel_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: req/dreq/we/rfwe/trap/wbsel=%b, want 0", {imem_req_o, dmem_req_o, dmem_we_o, rf_we_o, trap_o, wb_sel_o});
    end
  endtask

  task automatic test_alu();
    logic [4:0] rf_hist;
    do_reset();
    imem_word = W_ADDI;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL alu_fetch_c0: req=%b addr=%h, want req=1 addr=0", imem_req_o, imem_addr_o);
    end
    rf_hist = 5'b0;
    rf_hist[0] = rf_we_o;
    for (int c = 1; c <= 4; c++) begin
      step(1);
      rf_hist[c] = rf_we_o;
      if (c == 4) begin
        checks++;
        if (wb_sel_o !== 2'd0) begin
          errors++;
          $display("FAIL alu_wb_sel: got %0d, want 0", wb_sel_o);
        end
      end
    end
    checks++;
    if (rf_hist !== 5'b10000) begin
      errors++;
      $display("FAIL alu_rf_we_timing: history %b, want 10000", rf_hist);
    end
    step(1);
    checks++;
    if (pc_o !== 32'h4 || instret_o !== 32'd1 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      errors++;
      $display("FAIL alu_retire: pc=%h instret=%0d req=%b addr=%h, want 4/1/1/4", pc_o, instret_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_load_wait();
    int req_cnt, rf_cnt;
    logic we_seen;
    do_reset();
    imem_word = W_LW;
    d_gnt_dly = 3;
    req_cnt = 0; rf_cnt = 0; we_seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (dmem_req_o) req_cnt++;
      if (dmem_req_o && dmem_we_o) we_seen = 1'b1;
      if (rf_we_o) rf_cnt++;
      if (c == 9) begin
        checks++;
        if (rf_we_o !== 1'b1 || wb_sel_o !== 2'd1) begin
          errors++;
          $display("FAIL load_wb: cycle9 rf_we=%b wb_sel=%0d, want 1/1", rf_we_o, wb_sel_o);
        end
      end
    end
    checks++;
    if (req_cnt != 4 || we_seen !== 1'b0) begin
      errors++;
      $display("FAIL load_req_hold: req cycles=%0d we_seen=%b, want 4/0", req_cnt, we_seen);
    end
    checks++;
    if (rf_cnt != 1 || pc_o !== 32'h4 || instret_o !== 32'd1) begin
      errors++;
      $display("FAIL load_retire: rf pulses=%0d pc=%h instret=%0d, want 1/4/1", rf_cnt, pc_o, instret_o);
    end
  endtask

  task automatic test_branch();
    int rf_cnt;
    do_reset();
    imem_word = W_BEQ;
    branch_taken_i = 1'b1; target_i = 32'h40;
    rf_cnt = 0;
    for (int c = 1; c <= 5; c++) begin step(1); if (rf_we_o) rf_cnt++; end
    checks++;
    if (rf_cnt != 0 || pc_o !== 32'h40 || imem_addr_o !== 32'h40) begin
      errors++;
      $display("FAIL branch_taken: rf pulses=%0d pc=%h addr=%h, want 0/40/40", rf_cnt, pc_o, imem_addr_o);
    end
    branch_taken_i = 1'b0; target_i = 32'h80;
    for (int c = 1; c <= 5; c++) begin step(1); if (rf_we_o) rf_cnt++; end
    checks++;
    if (rf_cnt != 0 || pc_o !== 32'h44 || instret_o !== 32'd2) begin
      errors++;
      $display("FAIL branch_not_taken: rf pulses=%0d pc=%h instret=%0d, want 0/44/2", rf_cnt, pc_o, instret_o);
    end
  endtask

  task automatic test_jump_wrap();
    do_reset();
    imem_word = W_JAL;
    target_i = 32'hFFFF_FFFC;
    step(5);
    checks++;
    if (pc_o !== 32'hFFFF_FFFC || imem_addr_o !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL jal_to_top: pc=%h addr=%h, want fffffffc", pc_o, imem_addr_o);
    end
    target_i = 32'h8;
    step(4);
    checks++;
    if (wb_sel_o !== 2'd2 || rf_we_o !== 1'b1) begin
      errors++;
      $display("FAIL jal_wb_sel: wb_sel=%0d rf_we=%b, want 2/1", wb_sel_o, rf_we_o);
    end
    step(1);
    checks++;
    if (pc_o !== 32'h8) begin
      errors++;
      $display("FAIL jal_target: pc=%h, want 00000008", pc_o);
    end
    target_i = 32'hFFFF_FFFC;
    step(5);
    imem_word = W_NOP;
    step(4);
    checks++;
    if (wb_sel_o !== 2'd0 || rf_we_o !== 1'b1) begin
      errors++;
      $display("FAIL nop_wb: wb_sel=%0d rf_we=%b, want 0/1", wb_sel_o, rf_we_o);
    end
    step(1);
    checks++;
    if (pc_o !== 32'h0 || instret_o !== 32'd4) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h instret=%0d, want 0/4", pc_o, instret_o);
    end
  endtask

  task automatic test_trap();
    logic req_seen, trap_held;
    do_reset();
    imem_word = W_BAD;
    step(3);
    checks++;
    if (trap_o !== 1'b1 || rf_we_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_trap: trap=%b rf_we=%b, want 1/0", trap_o, rf_we_o);
    end
    req_seen = 1'b0; trap_held = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1);
      req_seen  = req_seen | imem_req_o | dmem_req_o | rf_we_o;
      trap_held = trap_held & trap_o;
    end
    checks++;
    if (req_seen !== 1'b0 || trap_held !== 1'b1) begin
      errors++;
      $display("FAIL trap_sticky: activity=%b trap_held=%b, want 0/1", req_seen, trap_held);
    end
    do_reset();
    checks++;
    if (trap_o !== 1'b0) begin
      errors++;
      $display("FAIL trap_cleared: trap=%b after reset, want 0", trap_o);
    end
    imem_word = W_JALR;
    target_i = 32'h102;
    step(4);
    checks++;
    if (trap_o !== 1'b1 || rf_we_o !== 1'b0 || pc_o !== 32'h0 || instret_o !== 32'd0) begin
      errors++;
      $display("FAIL jalr_misaligned: trap=%b rf_we=%b pc=%h instret=%0d, want 1/0/0/0", trap_o, rf_we_o, pc_o, instret_o);
    end
  endtask

  task automatic test_reset_mwait();
    int rf_cnt;
    do_reset();
    imem_word = W_LW;
    d_rv_dly = 6;
    step(6);
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({imem_req_o, dmem_req_o, rf_we_o, trap_o, wb_sel_o} !== 6'b0 ||
        pc_o !== 32'h0 || inst_o !== W_NOP || instret_o !== 32'h0) begin
      errors++;
      $display("FAIL mwait_reset: strobes=%b pc=%h inst=%h instret=%0d, want 0/0/00000013/0",
               {imem_req_o, dmem_req_o, rf_we_o, trap_o, wb_sel_o}, pc_o, inst_o, instret_o);
    end
    imem_word = W_ADDI;
    do_reset();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL restart_fetch: req=%b addr=%h, want 1/0", imem_req_o, imem_addr_o);
    end
    rf_cnt = 0;
    for (int c = 1; c <= 5; c++) begin step(1); if (rf_we_o) rf_cnt++; end
    checks++;
    if (rf_cnt != 1 || pc_o !== 32'h4 || instret_o !== 32'd1 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL restart_exec: rf pulses=%0d pc=%h instret=%0d dreq=%b, want 1/4/1/0", rf_cnt, pc_o, instret_o, dmem_req_o);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    branch_taken_i = 1'b0;
    target_i = 32'h0;
    imem_word = W_NOP;
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_jump_wrap();
    test_trap();
    test_reset_mwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
